// File: rtl/twiddle_mul.sv
// Twiddle multiplier behind a radix-2 SDF butterfly. DIFF-half samples are rotated by W_N^k and
// SUM-half samples by 1, both through the same 3-stage pipeline. Optional macro: TWM_SAT_EN.
module twiddle_mul #(
    parameter int IN_WIDTH  = 13,
    parameter int OUT_WIDTH = 13,
    parameter int TW_WIDTH  = 16,
    parameter int NUM_PAIR  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          din_valid,
    input  logic signed [IN_WIDTH-1:0]    din_re,
    input  logic signed [IN_WIDTH-1:0]    din_im,
    input  logic                          frame_sync,
    output logic                          dout_valid,
    output logic signed [OUT_WIDTH-1:0]   dout_re,
    output logic signed [OUT_WIDTH-1:0]   dout_im,
    output logic [$clog2(2*NUM_PAIR)-1:0] dout_idx,
    output logic                          frame_done,
    output logic                          sat_flag
);

    localparam int  IW     = $clog2(2*NUM_PAIR);
    localparam int  KW     = IW - 1;
    localparam int  FRAC   = TW_WIDTH - 2;
    localparam int  PW     = IN_WIDTH + TW_WIDTH;
    localparam int  SW     = PW + 2;
    localparam int  STAGES = 3;
    localparam real PI     = 3.14159265358979323846;

    localparam logic [IW-1:0]              LAST = IW'(2*NUM_PAIR - 1);
    localparam logic signed [TW_WIDTH-1:0] ONE  = TW_WIDTH'(1 << FRAC);
    localparam logic signed [SW-1:0]       RND  = SW'(1) <<< (FRAC - 1);
`ifdef TWM_SAT_EN
    localparam logic signed [SW-1:0]       OMAX = SW'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [SW-1:0]       OMIN = SW'(-(1 << (OUT_WIDTH-1)));
`endif

    // Symmetric round-to-nearest so +/- table entries quantise identically.
    function automatic int q_round(input real x);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
    endfunction

    function automatic int tw_cos(input int k);
        return q_round($cos(2.0 * PI * real'(k) / real'(2*NUM_PAIR)) * real'(1 << FRAC));
    endfunction

    function automatic int tw_nsin(input int k);
        return -q_round($sin(2.0 * PI * real'(k) / real'(2*NUM_PAIR)) * real'(1 << FRAC));
    endfunction

    logic signed [TW_WIDTH-1:0] cos_tab [NUM_PAIR];
    logic signed [TW_WIDTH-1:0] sin_tab [NUM_PAIR];

    for (genvar k = 0; k < NUM_PAIR; k++) begin : g_tab
        localparam int CK = tw_cos(k);
        localparam int DK = tw_nsin(k);
        assign cos_tab[k] = TW_WIDTH'(CK);
        assign sin_tab[k] = TW_WIDTH'(DK);
    end

    // Sample index: frame_sync wins over the running count for the current sample.
    logic [IW-1:0] idx, s_idx;
    logic [KW-1:0] k_sel;
    assign s_idx = frame_sync ? '0 : idx;
    assign k_sel = s_idx[KW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           idx <= '0;
        else if (din_valid)  idx <= (s_idx == LAST) ? '0 : s_idx + IW'(1);
        else if (frame_sync) idx <= '0;
    end

    logic [STAGES:1]            vld_pipe;
    logic signed [IN_WIDTH-1:0] a1, b1;
    logic signed [TW_WIDTH-1:0] c1, d1;
    logic [IW-1:0]              idx1, idx2;
    logic signed [PW-1:0]       ac, bd, ad, bc;
    logic signed [OUT_WIDTH-1:0] re_lim, im_lim;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0; idx1 <= '0;
            ac <= '0; bd <= '0; ad <= '0; bc <= '0; idx2 <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], din_valid};
            if (din_valid) begin
                a1   <= din_re;
                b1   <= din_im;
                c1   <= s_idx[IW-1] ? cos_tab[k_sel] : ONE;
                d1   <= s_idx[IW-1] ? sin_tab[k_sel] : '0;
                idx1 <= s_idx;
            end
            if (vld_pipe[1]) begin
                ac   <= PW'(a1) * PW'(c1);
                bd   <= PW'(b1) * PW'(d1);
                ad   <= PW'(a1) * PW'(d1);
                bc   <= PW'(b1) * PW'(c1);
                idx2 <= idx1;
            end
        end
    end

`ifdef TWM_SAT_EN
    logic signed [SW-1:0] re_sh, im_sh;
    logic re_hi, re_lo, im_hi, im_lo, clip;
    assign re_sh  = (SW'(ac) - SW'(bd) + RND) >>> FRAC;
    assign im_sh  = (SW'(ad) + SW'(bc) + RND) >>> FRAC;
    assign re_hi  = re_sh > OMAX;
    assign re_lo  = re_sh < OMIN;
    assign im_hi  = im_sh > OMAX;
    assign im_lo  = im_sh < OMIN;
    assign re_lim = re_hi ? OUT_WIDTH'(OMAX) : re_lo ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(re_sh);
    assign im_lim = im_hi ? OUT_WIDTH'(OMAX) : im_lo ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(im_sh);
    assign clip   = re_hi | re_lo | im_hi | im_lo;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     sat_flag <= 1'b0;
        else if (vld_pipe[2] && clip)  sat_flag <= 1'b1;
    end
`else
    // Without saturation the upper bits are simply dropped.
    assign re_lim   = OUT_WIDTH'((SW'(ac) - SW'(bd) + RND) >>> FRAC);
    assign im_lim   = OUT_WIDTH'((SW'(ad) + SW'(bc) + RND) >>> FRAC);
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_re    <= '0;
            dout_im    <= '0;
            dout_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            dout_re    <= vld_pipe[2] ? re_lim : '0;
            dout_im    <= vld_pipe[2] ? im_lim : '0;
            dout_idx   <= vld_pipe[2] ? idx2 : '0;
            frame_done <= vld_pipe[2] && (idx2 == LAST);
        end
    end

    assign dout_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_twiddle_mul.sv
// Bench for twiddle_mul: directed table at NUM_PAIR=16 plus random frames on NUM_PAIR=2,4,8,16.
`timescale 1ns/1ps
module tb_twiddle_mul;
    localparam int NI = 4;
    localparam int M  = 3;
`ifdef TWM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0, rstn = 1'b0, din_valid = 1'b0, frame_sync = 1'b0;
    logic signed [12:0] din_re = '0, din_im = '0;
    logic               dv [NI];
    logic signed [12:0] dre [NI];
    logic signed [12:0] dim [NI];
    logic [4:0]         didx [NI];
    logic               fd [NI];
    logic               sf [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NP = 2 << g;
        logic [$clog2(2*NP)-1:0] idx_w;
        twiddle_mul #(.IN_WIDTH(13), .OUT_WIDTH(13), .TW_WIDTH(16), .NUM_PAIR(NP)) dut (
            .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
            .frame_sync(frame_sync), .dout_valid(dv[g]), .dout_re(dre[g]), .dout_im(dim[g]),
            .dout_idx(idx_w), .frame_done(fd[g]), .sat_flag(sf[g]));
        assign didx[g] = 5'(idx_w);
    end

    typedef struct { int re; int im; int idx; bit fd; int cyc; } out_t;
    typedef struct { int a; int b; bit sync; int re; int im; int idx; bit fd; } vec_t;

    out_t q [NI][$];
    vec_t tbl [$];
    int   cyc = 0;
    int   checks = 0, failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int g = 0; g < NI; g++)
            if (dv[g]) q[g].push_back('{int'(dre[g]), int'(dim[g]), int'(didx[g]), fd[g], cyc});

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int lim(input longint v, output logic c);
        logic signed [12:0] w;
        c = 1'b0;
        if (SAT) begin
            if (v > 4095)  begin c = 1'b1; return 4095;  end
            if (v < -4096) begin c = 1'b1; return -4096; end
            return int'(v);
        end
        w = v[12:0];
        return int'(w);
    endfunction

    function automatic void ref_mul(input int a, input int b, input int idx, input int np,
                                    output int re, output int im, output logic clip);
        int c, d;
        real th;
        longint r, i;
        logic c1, c2;
        c = 16384; d = 0;
        if (idx >= np) begin
            th = 2.0 * 3.141592653589793 * real'(idx - np) / real'(2 * np);
            c  = int'($floor($cos(th) * 16384.0 + 0.5));
            d  = -int'($floor($sin(th) * 16384.0 + 0.5));
        end
        r  = (longint'(a) * c - longint'(b) * d + 8192) >>> 14;
        i  = (longint'(a) * d + longint'(b) * c + 8192) >>> 14;
        re = lim(r, c1);
        im = lim(i, c2);
        clip = c1 | c2;
    endfunction

    function automatic void add(input int a, input int b, input bit s, input int re, input int im,
                                input int idx, input bit f);
        tbl.push_back('{a, b, s, re, im, idx, f});
    endfunction

    task automatic drive(input bit v, input int a, input int b, input bit s);
        @(negedge clk);
        din_valid = v; din_re = 13'(a); din_im = 13'(b); frame_sync = s;
    endtask

    task automatic clear_q();
        @(posedge clk);
        for (int g = 0; g < NI; g++) q[g].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_q();
    endtask

    task automatic wait_outs(input int g, input int n, input string name);
        int t;
        t = 0;
        while (q[g].size() < n && t < 300) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        check({name, " output count"}, q[g].size(), n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, er, ei, n, np;
        logic cl, acc;
        int ra [$];
        int rb [$];

        // Frame A: constant (100,-50) across a full 32-sample frame.
        for (int i = 0; i < 32; i++) begin
            ref_mul(100, -50, i, 16, er, ei, cl);
            if (i <= 16) begin er = 100; ei = -50; end
            if (i == 24) begin er = -50; ei = -100; end
            add(100, -50, 1'b0, er, ei, i, i == 31);
        end
        for (int i = 0; i < 7; i++) add(10, 20, 1'b0, 10, 20, i, 1'b0);
        add(300, -200, 1'b1, 300, -200, 0, 1'b0);
        add(7, 7, 1'b0, 7, 7, 1, 1'b0);
        for (int i = 2; i < 20; i++) add(0, 0, 1'b0, 0, 0, i, 1'b0);
        add(-4096, -4096, 1'b0, SAT ? -4096 : 2400, 0, 20, 1'b0);
        for (int i = 21; i < 32; i++) add(0, 0, 1'b0, 0, 0, i, i == 31);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset dout_valid", dv[M], 0);
        check("reset dout_re/im", {dre[M], dim[M]}, 0);
        check("reset dout_idx", didx[M], 0);
        check("reset frame_done", fd[M], 0);
        check("reset sat_flag", sf[M], 0);
        rstn = 1'b1;
        clear_q();

        // Directed table, back to back
        t0 = 0;
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].sync);
            if (i == 0) t0 = cyc;
        end
        drive(1'b0, 0, 0, 1'b0);
        wait_outs(M, tbl.size(), "table");
        if (q[M].size() > 0) check("first sample latency", q[M][0].cyc - t0, 3);
        foreach (tbl[i]) begin
            if (i < q[M].size()) begin
                check($sformatf("vec%0d re", i), q[M][i].re, tbl[i].re);
                check($sformatf("vec%0d im", i), q[M][i].im, tbl[i].im);
                check($sformatf("vec%0d idx", i), q[M][i].idx, tbl[i].idx);
                check($sformatf("vec%0d frame_done", i), q[M][i].fd, tbl[i].fd);
            end
        end
        check("sat_flag after k=4 overflow", sf[M], SAT);
        clear_q();

        // Gapped frame: 16 idle cycles between samples must give the gap-free results
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 100, -50, 1'b0);
            for (int j = 1; j <= 16; j++) begin
                drive(1'b0, 0, 0, 1'b0);
                if (j == 8) check($sformatf("gap%0d outputs zero", i),
                                  {dv[M], dre[M], dim[M], didx[M], fd[M]}, 0);
            end
        end
        wait_outs(M, 32, "gapped");
        for (int i = 0; i < 32 && i < q[M].size(); i++) begin
            check($sformatf("gap vec%0d re", i), q[M][i].re, tbl[i].re);
            check($sformatf("gap vec%0d im", i), q[M][i].im, tbl[i].im);
            check($sformatf("gap vec%0d idx", i), q[M][i].idx, i);
        end
        check("sat_flag sticky", sf[M], SAT);

        // Reset with samples in flight: idx 31 at output, two more behind it
        for (int i = 0; i < 34; i++) drive(1'b1, i, -i, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check("pre-reset dout_valid", dv[M], 1);
        check("pre-reset frame_done", fd[M], 1);
        check("pre-reset sat_flag", sf[M], SAT);
        rstn = 1'b0;
        #1;
        check("async reset dout_valid", dv[M], 0);
        check("async reset frame_done", fd[M], 0);
        check("async reset sat_flag", sf[M], 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_q();
        drive(1'b1, 123, -45, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        wait_outs(M, 1, "post-reset");
        if (q[M].size() > 0) begin
            check("post-reset idx", q[M][0].idx, 0);
            check("post-reset re", q[M][0].re, 123);
            check("post-reset im", q[M][0].im, -45);
        end

        // Random frames on all four sizes at once
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                ra.push_back(int'($urandom_range(0, 8191)) - 4096);
                rb.push_back(int'($urandom_range(0, 8191)) - 4096);
                drive(1'b1, ra[$], rb[$], 1'b0);
            end else begin
                drive(1'b0, 0, 0, 1'b0);
            end
        end
        drive(1'b0, 0, 0, 1'b0);
        n = ra.size();
        for (int g = 0; g < NI; g++) begin
            np = 2 << g;
            acc = 1'b0;
            wait_outs(g, n, $sformatf("rand np%0d", np));
            for (int i = 0; i < n && i < q[g].size(); i++) begin
                ref_mul(ra[i], rb[i], i % (2 * np), np, er, ei, cl);
                acc = acc | cl;
                check($sformatf("rand np%0d #%0d re", np, i), q[g][i].re, er);
                check($sformatf("rand np%0d #%0d im", np, i), q[g][i].im, ei);
                check($sformatf("rand np%0d #%0d idx", np, i), q[g][i].idx, i % (2 * np));
                check($sformatf("rand np%0d #%0d frame_done", np, i), q[g][i].fd,
                      (i % (2 * np)) == 2 * np - 1);
            end
            check($sformatf("rand np%0d sat_flag", np), sf[g], acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
